lamp_driver: RTL and testbench

//   Lamp output stage of the bound flasher. Consumes the 2-bit control code from
//   the control FSM and maintains the N-lamp thermometer bar: grows it, shrinks it,

---
 rtl/lamp_if.sv | 16 +
 rtl/lamp_driver.sv | 91 +++++++++
 tb/tb_lamp_driver.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lamp_if.sv
// Control/lamp bundle between the bound-flasher control FSM (master) and the
// lamp output stage (slave).
interface lamp_if #(
  parameter int unsigned N_LAMP = 16,
  parameter int unsigned CW     = $clog2(N_LAMP + 1)
);
  logic [1:0]        control;
  logic [N_LAMP-1:0] lamp;
  logic [CW-1:0]     lit_cnt;
  logic              step;
  logic              full;
  logic              empty;

  modport master (output control, input lamp, lit_cnt, step, full, empty);
  modport slave  (input control, output lamp, lit_cnt, step, full, empty);
endinterface

// File: rtl/lamp_driver.sv
// Lamp output stage: keeps an N-lamp thermometer bar that grows, shrinks, holds
// or clears one lamp per divided step, as commanded by the 2-bit control code.
module lamp_driver #(
  parameter int unsigned N_LAMP   = 16,
  parameter int unsigned STEP_DIV = 1,
  parameter int unsigned CW       = $clog2(N_LAMP + 1)
) (
  input logic   clk,
  input logic   rst_n,
  lamp_if.slave bus
);
  localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [1:0] CTL_HOLD      = 2'b00;
  localparam logic [1:0] CTL_SHIFT_ON  = 2'b01;
  localparam logic [1:0] CTL_SHIFT_OFF = 2'b10;
  localparam logic [1:0] CTL_CLEAR     = 2'b11;

  logic [1:0]        ctl_q;
  logic [DW-1:0]     div_cnt, div_nxt;
  logic [N_LAMP-1:0] lamp_q, lamp_nxt;
  logic [CW-1:0]     cnt_q, cnt_nxt;
  logic              step_q, step_nxt;
  logic              full_q, empty_q;
  logic              chg, tick;

  // Divider and next bar state; a code change restarts step timing from zero.
  always_comb begin
    chg      = (bus.control != ctl_q);
    tick     = 1'b0;
    div_nxt  = '0;
    lamp_nxt = lamp_q;
    cnt_nxt  = cnt_q;
    step_nxt = 1'b0;

    if ((bus.control == CTL_SHIFT_ON || bus.control == CTL_SHIFT_OFF) && !chg) begin
      tick    = (div_cnt == DW'(STEP_DIV - 1));
      div_nxt = tick ? '0 : div_cnt + DW'(1);
    end

    case (bus.control)
      CTL_CLEAR: begin
        lamp_nxt = '0;
        cnt_nxt  = '0;
      end
      CTL_SHIFT_ON: begin
        if (tick && !full_q) begin
          lamp_nxt = {lamp_q[N_LAMP-2:0], 1'b1};
          cnt_nxt  = cnt_q + CW'(1);
          step_nxt = 1'b1;
        end
      end
      CTL_SHIFT_OFF: begin
        if (tick && !empty_q) begin
          lamp_nxt = {1'b0, lamp_q[N_LAMP-1:1]};
          cnt_nxt  = cnt_q - CW'(1);
          step_nxt = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // full/empty are registered from the next count so they always track lit_cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q   <= CTL_HOLD;
      div_cnt <= '0;
      lamp_q  <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      ctl_q   <= bus.control;
      div_cnt <= div_nxt;
      lamp_q  <= lamp_nxt;
      cnt_q   <= cnt_nxt;
      step_q  <= step_nxt;
      full_q  <= (cnt_nxt == CW'(N_LAMP));
      empty_q <= (cnt_nxt == '0);
    end
  end

  assign bus.lamp    = lamp_q;
  assign bus.lit_cnt = cnt_q;
  assign bus.step    = step_q;
  assign bus.full    = full_q;
  assign bus.empty   = empty_q;
endmodule

// File: tb/tb_lamp_driver.sv
// Directed bench for lamp_driver: one instance with STEP_DIV=1, one with STEP_DIV=3.
module tb_lamp_driver;
  logic clk;
  logic rst_n;
  logic chk_en;
  int   n_tests;
  int   n_fail;

  lamp_if #(.N_LAMP(16)) b1 ();
  lamp_if #(.N_LAMP(16)) b3 ();

  lamp_driver #(.N_LAMP(16), .STEP_DIV(1)) u_div1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  lamp_driver #(.N_LAMP(16), .STEP_DIV(3)) u_div3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] therm(input int n);
    logic [16:0] v;
    v = (17'd1 << n) - 17'd1;
    return v[15:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    b1.control = 2'b00;
    b3.control = 2'b00;
    cyc();
    rst_n = 1'b1;
  endtask

  // Thermometer invariant and full/empty decode, checked on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (b1.lamp !== therm(int'(b1.lit_cnt)) || b1.full !== (b1.lit_cnt == 5'd16)
          || b1.empty !== (b1.lit_cnt == 5'd0)) begin
        n_fail++;
        $display("FAIL inv_div1: lamp=%h lit_cnt=%0d full=%b empty=%b, required lamp=%h",
                 b1.lamp, b1.lit_cnt, b1.full, b1.empty, therm(int'(b1.lit_cnt)));
      end
      n_tests++;
      if (b3.lamp !== therm(int'(b3.lit_cnt)) || b3.full !== (b3.lit_cnt == 5'd16)
          || b3.empty !== (b3.lit_cnt == 5'd0)) begin
        n_fail++;
        $display("FAIL inv_div3: lamp=%h lit_cnt=%0d full=%b empty=%b, required lamp=%h",
                 b3.lamp, b3.lit_cnt, b3.full, b3.empty, therm(int'(b3.lit_cnt)));
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    b1.control = 2'b01;
    b3.control = 2'b00;
    cyc();
    cyc();
    n_tests++;
    if ({b1.lamp, b1.lit_cnt, b1.step, b1.empty, b1.full} !== {16'h0000, 5'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: lamp=%h lit=%0d step=%b empty=%b full=%b, required 0000 0 0 1 0",
               b1.lamp, b1.lit_cnt, b1.step, b1.empty, b1.full);
    end
    chk_en = 1'b1;
    rst_n = 1'b1;
    cyc();
    n_tests++;
    if ({b1.lamp, b1.step} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release_chg: lamp=%h step=%b, required 0000 0", b1.lamp, b1.step);
    end
    cyc();
    n_tests++;
    if ({b1.lamp, b1.lit_cnt, b1.step} !== {16'h0001, 5'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_first_step: lamp=%h lit=%0d step=%b, required 0001 1 1",
               b1.lamp, b1.lit_cnt, b1.step);
    end
  endtask

  task automatic test_shift_on();
    do_reset();
    b1.control = 2'b01;
    cyc();
    n_tests++;
    if ({b1.lamp, b1.step} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL on_chg_cycle: lamp=%h step=%b, required 0000 0", b1.lamp, b1.step);
    end
    for (int i = 1; i <= 16; i++) begin
      cyc();
      n_tests++;
      if ({b1.lamp, b1.lit_cnt, b1.step} !== {therm(i), 5'(i), 1'b1}) begin
        n_fail++;
        $display("FAIL on_step%0d: lamp=%h lit=%0d step=%b, required %h %0d 1",
                 i, b1.lamp, b1.lit_cnt, b1.step, therm(i), i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_tests++;
      if ({b1.lamp, b1.step, b1.full} !== {16'hFFFF, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL on_saturate%0d: lamp=%h step=%b full=%b, required ffff 0 1",
                 i, b1.lamp, b1.step, b1.full);
      end
    end
  endtask

  task automatic test_shift_off();
    b1.control = 2'b10;
    cyc();
    n_tests++;
    if ({b1.lamp, b1.step} !== {16'hFFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL off_chg_cycle: lamp=%h step=%b, required ffff 0", b1.lamp, b1.step);
    end
    for (int i = 15; i >= 0; i--) begin
      cyc();
      n_tests++;
      if ({b1.lamp, b1.lit_cnt, b1.step} !== {therm(i), 5'(i), 1'b1}) begin
        n_fail++;
        $display("FAIL off_step%0d: lamp=%h lit=%0d step=%b, required %h %0d 1",
                 i, b1.lamp, b1.lit_cnt, b1.step, therm(i), i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++;
      if ({b1.lamp, b1.lit_cnt, b1.step, b1.empty} !== {16'h0000, 5'd0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL off_saturate%0d: lamp=%h lit=%0d step=%b empty=%b, required 0000 0 0 1",
                 i, b1.lamp, b1.lit_cnt, b1.step, b1.empty);
      end
    end
  endtask

  task automatic test_div3();
    logic [15:0] exp_lamp;
    logic        exp_step;
    do_reset();
    b3.control = 2'b01;
    for (int k = 0; k <= 13; k++) begin
      if (k == 10) b3.control = 2'b10;
      cyc();
      exp_step = (k == 3 || k == 6 || k == 9 || k == 13);
      if (k < 3)       exp_lamp = 16'h0000;
      else if (k < 6)  exp_lamp = 16'h0001;
      else if (k < 9)  exp_lamp = 16'h0003;
      else if (k < 13) exp_lamp = 16'h0007;
      else             exp_lamp = 16'h0003;
      n_tests++;
      if ({b3.lamp, b3.step} !== {exp_lamp, exp_step}) begin
        n_fail++;
        $display("FAIL div3_cycle%0d: lamp=%h step=%b, required %h %b",
                 k, b3.lamp, b3.step, exp_lamp, exp_step);
      end
    end
  endtask

  task automatic test_clear_hold();
    do_reset();
    b1.control = 2'b01;
    repeat (7) cyc();
    n_tests++;
    if (b1.lamp !== 16'h003F) begin
      n_fail++;
      $display("FAIL clear_setup: lamp=%h, required 003f", b1.lamp);
    end
    b1.control = 2'b11;
    cyc();
    n_tests++;
    if ({b1.lamp, b1.lit_cnt, b1.step} !== {16'h0000, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL clear: lamp=%h lit=%0d step=%b, required 0000 0 0", b1.lamp, b1.lit_cnt, b1.step);
    end
    b1.control = 2'b01;
    repeat (4) cyc();
    b1.control = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++;
      if ({b1.lamp, b1.lit_cnt, b1.step} !== {16'h0007, 5'd3, 1'b0}) begin
        n_fail++;
        $display("FAIL hold%0d: lamp=%h lit=%0d step=%b, required 0007 3 0",
                 i, b1.lamp, b1.lit_cnt, b1.step);
      end
    end
    n_tests++;
    if (u_div1.div_cnt !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_div_cnt: div_cnt=%0d, required 0", u_div1.div_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    b1.control = 2'b01;
    repeat (12) cyc();
    n_tests++;
    if (b1.lamp !== 16'h07FF) begin
      n_fail++;
      $display("FAIL mid_setup: lamp=%h, required 07ff", b1.lamp);
    end
    rst_n = 1'b0;
    cyc();
    n_tests++;
    if ({b1.lamp, b1.lit_cnt, b1.step} !== {16'h0000, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: lamp=%h lit=%0d step=%b, required 0000 0 0", b1.lamp, b1.lit_cnt, b1.step);
    end
    rst_n = 1'b1;
    cyc();
    n_tests++;
    if ({b1.lamp, b1.step} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_release_chg: lamp=%h step=%b, required 0000 0", b1.lamp, b1.step);
    end
    cyc();
    n_tests++;
    if ({b1.lamp, b1.step} !== {16'h0001, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_restart: lamp=%h step=%b, required 0001 1", b1.lamp, b1.step);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    rst_n   = 1'b0;
    b1.control = 2'b00;
    b3.control = 2'b00;
    test_reset();
    test_shift_on();
    test_shift_off();
    test_div3();
    test_clear_hold();
    test_reset_mid();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
